// File: rtl/seven_seg_mux_n.sv
// seven_seg_mux_n: round-robin N-digit seven-segment multiplexer with slot blanking and slot/frame strobes
module seven_seg_mux_n #(
  parameter int NUM_DIGITS   = 4,
  parameter int SEG_W        = 7,
  parameter int PERIOD       = 40000,
  parameter int CBITS        = 16,
  parameter int BLANK_CYCLES = 16,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_DIGITS*SEG_W-1:0]   segs_in,
  input  logic                          load,
  input  logic [NUM_DIGITS-1:0]         digit_en,
  output logic [SEG_W-1:0]              segment,
  output logic [NUM_DIGITS-1:0]         digit_sel,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          sig,
  output logic                          frame_done
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [SEG_W-1:0] SEG_OFF = {SEG_W{ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{ACTIVE_LOW}};
  logic [CBITS-1:0] r_cnt, w_cnt_nxt;
  logic [IW-1:0] r_idx, w_idx_nxt, w_nidx, w_lo, w_hi;
  logic w_has_hi, w_tick, w_blank;
  logic [NUM_DIGITS*SEG_W-1:0] r_shadow, w_sh_nxt;
  logic [SEG_W-1:0] w_dig [NUM_DIGITS];
  logic [SEG_W-1:0] r_seg;
  logic [NUM_DIGITS-1:0] r_sel;
  logic r_sig, r_frame;
  assign w_sh_nxt = load ? segs_in : r_shadow;
  genvar k;
  for (k = 0; k < NUM_DIGITS; k++) begin : g_dig
    assign w_dig[k] = w_sh_nxt[k*SEG_W +: SEG_W];
  end
  // Downward scan so the lowest enabled index wins; an empty mask holds idx
  always_comb begin
    w_lo = r_idx;
    w_hi = r_idx;
    w_has_hi = 1'b0;
    for (int i = NUM_DIGITS-1; i >= 0; i--) begin
      if (digit_en[i]) begin
        w_lo = IW'(i);
        if (IW'(i) > r_idx) begin
          w_hi = IW'(i);
          w_has_hi = 1'b1;
        end
      end
    end
    w_nidx = w_has_hi ? w_hi : w_lo;
  end
  assign w_tick    = r_cnt == CBITS'(PERIOD-1);
  assign w_cnt_nxt = w_tick ? '0 : r_cnt + 1'b1;
  assign w_idx_nxt = w_tick ? w_nidx : r_idx;
  assign w_blank   = int'(w_cnt_nxt) < BLANK_CYCLES || !digit_en[w_idx_nxt] || ~|digit_en;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_idx    <= '0;
      r_shadow <= '0;
      r_seg    <= SEG_OFF;
      r_sel    <= SEL_OFF;
      r_sig    <= 1'b0;
      r_frame  <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_idx    <= w_idx_nxt;
      r_shadow <= w_sh_nxt;
      r_seg    <= w_blank ? SEG_OFF : w_dig[w_idx_nxt] ^ SEG_OFF;
      r_sel    <= w_blank ? SEL_OFF : (NUM_DIGITS'(1) << w_idx_nxt) ^ SEL_OFF;
      r_sig    <= w_tick;
      r_frame  <= w_tick && (w_nidx <= r_idx);
    end
  end
  assign segment    = r_seg;
  assign digit_sel  = r_sel;
  assign digit_idx  = r_idx;
  assign sig        = r_sig;
  assign frame_done = r_frame;
endmodule

// File: tb/tb_seven_seg_mux_n.sv
// tb_seven_seg_mux_n: directed stimulus with a per-cycle expectation queue checked against active-high and active-low instances
module tb_seven_seg_mux_n;
  localparam int N = 4, W = 7, P = 8, B = 2;
  logic clk = 1'b0, rst = 1'b1, load = 1'b0;
  logic [N*W-1:0] segs_in = '0;
  logic [N-1:0] digit_en = '0;
  logic [W-1:0] seg_h, seg_l, inv_seg;
  logic [N-1:0] sel_h, sel_l, inv_sel;
  logic [1:0] idx_h, idx_l;
  logic sig_h, sig_l, fd_h, fd_l;
  always #5 clk = ~clk;
  seven_seg_mux_n #(.NUM_DIGITS(N), .SEG_W(W), .PERIOD(P), .CBITS(16), .BLANK_CYCLES(B), .ACTIVE_LOW(1'b0)) u_hi (
    .clk(clk), .rst(rst), .segs_in(segs_in), .load(load), .digit_en(digit_en),
    .segment(seg_h), .digit_sel(sel_h), .digit_idx(idx_h), .sig(sig_h), .frame_done(fd_h));
  seven_seg_mux_n #(.NUM_DIGITS(N), .SEG_W(W), .PERIOD(P), .CBITS(16), .BLANK_CYCLES(B), .ACTIVE_LOW(1'b1)) u_lo (
    .clk(clk), .rst(rst), .segs_in(segs_in), .load(load), .digit_en(digit_en),
    .segment(seg_l), .digit_sel(sel_l), .digit_idx(idx_l), .sig(sig_l), .frame_done(fd_l));
  typedef struct {
    logic [W-1:0] seg;
    logic [N-1:0] sel;
    logic [1:0]   idx;
    logic         sig;
    logic         fd;
  } exp_t;
  exp_t q[$];
  exp_t me;
  int n_cmp = 0, n_bad = 0;
  int m_cnt = 0, m_idx = 0;
  logic [N*W-1:0] m_sh = '0;
  task automatic chk(string nm, logic [31:0] a, logic [31:0] x);
    n_cmp++;
    if (a !== x) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, a, x);
    end
  endtask
  // Reference: walk upward from the current digit with wrap to find the next enabled one
  task automatic cycle();
    exp_t e;
    int nc, ni;
    logic tick, blank, found;
    logic [N*W-1:0] sh;
    if (rst) begin
      m_cnt = 0;
      m_idx = 0;
      m_sh = '0;
      e.seg = '0; e.sel = '0; e.idx = '0; e.sig = 1'b0; e.fd = 1'b0;
    end else begin
      tick = (m_cnt == P-1);
      nc = tick ? 0 : m_cnt + 1;
      ni = m_idx;
      found = 1'b0;
      if (tick && digit_en != 0)
        for (int s = 1; s <= N; s++)
          if (!found && digit_en[(m_idx+s)%N]) begin
            ni = (m_idx+s)%N;
            found = 1'b1;
          end
      sh = load ? segs_in : m_sh;
      blank = (nc < B) || !digit_en[ni] || (digit_en == 0);
      e.seg = blank ? '0 : sh[ni*W +: W];
      e.sel = blank ? '0 : N'(1) << ni;
      e.idx = 2'(ni);
      e.sig = tick;
      e.fd = tick && (ni <= m_idx);
      m_cnt = nc;
      m_idx = ni;
      m_sh = sh;
    end
    q.push_back(e);
    @(negedge clk);
  endtask
  task automatic run(int n);
    repeat (n) cycle();
  endtask
  task automatic run_until(int idx, int cnt);
    int g = 0;
    while (!(m_idx == idx && m_cnt == cnt) && g < 100) begin
      cycle();
      g++;
    end
    if (g >= 100) begin
      n_cmp++;
      n_bad++;
      $display("FAIL run_until: slot idx=%0d cnt=%0d never reached", idx, cnt);
    end
  endtask
  always begin
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      me = q.pop_front();
      inv_seg = ~me.seg;
      inv_sel = ~me.sel;
      chk("seg_h", 32'(seg_h), 32'(me.seg));
      chk("sel_h", 32'(sel_h), 32'(me.sel));
      chk("idx_h", 32'(idx_h), 32'(me.idx));
      chk("sig_h", 32'(sig_h), 32'(me.sig));
      chk("fd_h", 32'(fd_h), 32'(me.fd));
      chk("seg_l", 32'(seg_l), 32'(inv_seg));
      chk("sel_l", 32'(sel_l), 32'(inv_sel));
      chk("idx_l", 32'(idx_l), 32'(me.idx));
      chk("sig_l", 32'(sig_l), 32'(me.sig));
      chk("fd_l", 32'(fd_l), 32'(me.fd));
      chk("onehot", 32'($onehot0(sel_h)), 32'd1);
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end
  initial begin
    @(negedge clk);
    rst = 1'b1;
    digit_en = 4'b1111;
    run(2);
    rst = 1'b0;
    load = 1'b1;
    segs_in = {7'h06, 7'h5B, 7'h4F, 7'h66};
    cycle();
    load = 1'b0;
    run(40);
    digit_en = 4'b1010;
    run(40);
    digit_en = 4'b1111;
    run_until(1, 4);
    digit_en = 4'b1101;
    run(16);
    digit_en = 4'b0000;
    run(20);
    digit_en = 4'b1111;
    run_until(2, 5);
    load = 1'b1;
    segs_in = {7'h7F, 7'h3F, 7'h77, 7'h39};
    cycle();
    load = 1'b0;
    run(8);
    rst = 1'b1;
    load = 1'b1;
    segs_in = '1;
    cycle();
    rst = 1'b0;
    load = 1'b0;
    run(20);
    load = 1'b1;
    segs_in = {7'h06, 7'h5B, 7'h4F, 7'h66};
    cycle();
    load = 1'b0;
    run_until(2, 5);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    run(40);
    repeat (2) @(negedge clk);
    chk("drain", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
